parity_frame_checker: RTL and testbench
=======================================

# parity_frame_checker

Parametrised streaming parity checker: accepts WIDTH-bit data words each carrying one parity bit and checks every word as it arrives. Words are grouped into frames of FRAME_LEN data words plus one longitudinal check word (bitwise XOR of the frame's data words), so each frame is also checked as a whole. Sits on the receive side of serial/parallel links, after deserialisation. It reports per-word errors, a per-frame verdict and a saturating bad-frame count.

## Interface
- WIDTH, 8: data word width in bits (≥1)
- FRAME_LEN, 4: data words per frame, excluding the check word (≥1)
- ODD, 0: 0 = even parity, 1 = odd parity
- CNT_W, 8: bad-frame counter width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  data word, or check word on the final beat of a frame
- in_par  in  1  parity bit transmitted with in_data
- pec_valid  out  1  pec is meaningful this cycle
- pec  out  1  word parity error on the previously accepted beat
- frame_done  out  1  one-cycle pulse at the end of each frame
- frame_err  out  1  frame verdict; valid only while frame_done=1
- clr_cnt  in  1  synchronous clear of err_cnt
- err_cnt  out  CNT_W  saturating count of frames with frame_err=1

## Operation
- Beat accepted on a rising edge where in_valid & in_ready.
- Word check, applied to every beat including the check word:
  - even mode: error = ^{in_data,in_par} != 0
  - odd mode: error = ^{in_data,in_par} != 1
- Internal registers: lrc[WIDTH-1:0]; beat counter (ceil(log2(FRAME_LEN)) bits, minimum 1); sticky word_err flag.
- States and transitions:
  - DATA (reset state): in_ready=1. Each accepted beat sets lrc ^= in_data and word_err |= error. On the FRAME_LEN-th beat, go to CHECK.
  - CHECK: in_ready=1. The accepted beat is the check word. Latch frame_err = word_err | error | (lrc != in_data). Go to REPORT.
  - REPORT: in_ready=0; frame_done=1. Clear lrc, word_err and the beat counter. Go to DATA.
- FRAME_LEN=1: one beat in DATA, then CHECK.
- The first frame_done after reset belongs to the first complete frame.
- Partial frames never produce frame_done.

## Timing
- Reset values:
  - in_ready=1, pec_valid=0, pec=0, frame_done=0, frame_err=0, err_cnt=0
  - state=DATA; lrc, word_err and beat counter cleared
- pec_valid/pec are registered and appear one cycle after acceptance. pec_valid=0 in any cycle following no acceptance.
- frame_done/frame_err appear in REPORT, the cycle after the check word is accepted. This is the same cycle as that word's pec_valid.
- Throughput: FRAME_LEN+1 beats per FRAME_LEN+2 cycles maximum; one bubble per frame.
- in_valid held while in_ready=0: the beat is not consumed. The source holds in_data and in_par stable.
- err_cnt increments on the REPORT-cycle edge when frame_err=1, visible the next cycle. It saturates at 2^CNT_W-1.
- clr_cnt on the same edge as an increment: clear wins, err_cnt=0.
- Reset asserted mid-frame: all state is discarded immediately (asynchronously) and the partial frame is lost.

## Configuration
- PARITY_FRAME_CNT_EN defined: err_cnt and clr_cnt behave as specified above.
- Not defined: counter logic is omitted, err_cnt is tied to 0 and clr_cnt is ignored. All other behaviour is identical.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid toggling → in_ready=1 and all other outputs 0. After release, no pec_valid until the first beat is accepted.
- Clean frame (WIDTH=8, FRAME_LEN=4, even mode): data beats 0x12/p0, 0x34/p1, 0x56/p0, 0x78/p0, then check word 0x08/p1 → five pec_valid pulses with pec=0. In the next cycle frame_done=1, frame_err=0, in_ready=0. err_cnt stays 0.
- Word error: send 0x13/p0 in place of 0x12 → pec=1 on that beat only. frame_err=1 (LRC also mismatches). err_cnt becomes 1 in the cycle after frame_done.
- LRC-only error: correct data beats, check word 0x09/p0 → all pec=0 but frame_err=1. Back-to-back frames with in_valid held high → in_ready drops for exactly one cycle per frame and no beat is lost.
- Saturation and clear (CNT_W=2): four bad frames → err_cnt 1,2,3,3. Assert clr_cnt on the REPORT cycle of a fifth bad frame → err_cnt=0.
- Reset mid-frame and odd mode (ODD=1): reset after 2 accepted beats, then send a clean odd-parity frame (0x12/p1, 0x34/p0, 0x56/p1, 0x78/p1, check 0x08/p0) → no frame_done for the partial frame, then one frame_done with frame_err=0.

Source files
------------

// File: rtl/parity_frame_checker.sv
// Streaming per-word parity and per-frame longitudinal (XOR) check with a bad-frame counter.
// Define PARITY_FRAME_CNT_EN to build the saturating err_cnt/clr_cnt logic; otherwise err_cnt is tied to 0.
//
// state    | meaning
// S_DATA   | accepting FRAME_LEN data words, folding them into lrc and word_err
// S_CHECK  | accepting the check word, latching the frame verdict
// S_REPORT | one-cycle bubble: frame_done pulse, frame state cleared
module parity_frame_checker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_par,
  output logic             o_pec_valid,
  output logic             o_pec,
  output logic             o_frame_done,
  output logic             o_frame_err,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int   BCW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic LP_ODD  = (ODD != 0);
  localparam logic [BCW-1:0] LP_LAST_BEAT = BCW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lrc;
  logic             r_word_err;
  logic [BCW-1:0]   r_beat;
  logic             r_frame_err;
  logic             r_pec_valid;
  logic             r_pec;

  logic w_accept;
  logic w_word_err;
  logic w_last_beat;

  // Parity over data+par is 0 for a clean even word and 1 for a clean odd word.
  assign w_word_err  = (^{i_in_data, i_in_par}) ^ LP_ODD;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last_beat = (r_beat == LP_LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DATA;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_in_ready   = 1'b1;
    o_frame_done = 1'b0;
    case (r_state)
      S_DATA: begin
        if (w_accept && w_last_beat) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_accept) begin
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        o_in_ready   = 1'b0;
        o_frame_done = 1'b1;
        w_state_nxt  = S_DATA;
      end
      default: begin
        w_state_nxt = S_DATA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrc       <= '0;
      r_word_err  <= 1'b0;
      r_beat      <= '0;
      r_frame_err <= 1'b0;
      r_pec_valid <= 1'b0;
      r_pec       <= 1'b0;
    end else begin
      r_pec_valid <= w_accept;
      r_pec       <= w_accept & w_word_err;
      case (r_state)
        S_DATA: begin
          if (w_accept) begin
            r_lrc      <= r_lrc ^ i_in_data;
            r_word_err <= r_word_err | w_word_err;
            if (!w_last_beat) begin
              r_beat <= r_beat + BCW'(1);
            end
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_frame_err <= r_word_err | w_word_err | (r_lrc != i_in_data);
          end
        end
        S_REPORT: begin
          r_lrc      <= '0;
          r_word_err <= 1'b0;
          r_beat     <= '0;
        end
        default: begin
          r_beat <= '0;
        end
      endcase
    end
  end

  assign o_pec_valid = r_pec_valid;
  assign o_pec       = r_pec;
  // The latched verdict is only presented during the frame_done pulse.
  assign o_frame_err = o_frame_done & r_frame_err;

`ifdef PARITY_FRAME_CNT_EN
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_err_cnt <= '0;
    end else if (o_frame_err && (r_err_cnt != LP_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_clr_cnt;
  assign o_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised and directed bench for parity_frame_checker; two instances (even/CNT_W=2 and odd/CNT_W=8)
// share stimulus, the odd one receiving inverted parity so both must report identical errors.
module tb_parity_frame_checker;

  localparam int FL   = 4;
  localparam int CW_A = 2;
  localparam int CW_B = 8;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_par;
  logic       i_clr;

  logic a_rdy, a_pv, a_pec, a_done, a_ferr;
  logic b_rdy, b_pv, b_pec, b_done, b_ferr;
  logic [CW_A-1:0] a_cnt;
  logic [CW_B-1:0] b_cnt;

  parity_frame_checker #(.WIDTH(8), .FRAME_LEN(FL), .ODD(0), .CNT_W(CW_A)) u_dut_even (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_valid), .o_in_ready(a_rdy),
    .i_in_data(i_data), .i_in_par(i_par), .o_pec_valid(a_pv), .o_pec(a_pec),
    .o_frame_done(a_done), .o_frame_err(a_ferr), .i_clr_cnt(i_clr), .o_err_cnt(a_cnt)
  );

  parity_frame_checker #(.WIDTH(8), .FRAME_LEN(FL), .ODD(1), .CNT_W(CW_B)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_valid), .o_in_ready(b_rdy),
    .i_in_data(i_data), .i_in_par(~i_par), .o_pec_valid(b_pv), .o_pec(b_pec),
    .o_frame_done(b_done), .o_frame_err(b_ferr), .i_clr_cnt(i_clr), .o_err_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: position within the frame, the words received so far, and the verdict.
  int         m_pos;
  logic       m_bubble;
  logic       m_ferr;
  logic [7:0] m_w [FL+1];
  logic       m_p [FL+1];
  int         cnt_a;
  int         cnt_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic perr(input logic [7:0] d, input logic p);
    return ($countones({d, p}) % 2) != 0;
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef PARITY_FRAME_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic model_reset();
    m_pos = 0; m_bubble = 1'b0; m_ferr = 1'b0; cnt_a = 0; cnt_b = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic c, output logic acc);
    logic e_rdy;
    logic [7:0] lrc;
    logic bad;
    @(negedge clk);
    i_valid = v; i_data = d; i_par = p; i_clr = c;
    e_rdy = !m_bubble;
    #1;
    chk("ready_a", a_rdy, e_rdy);
    chk("ready_b", b_rdy, e_rdy);
    @(posedge clk);
    acc = v & e_rdy;
    if (c) begin
      cnt_a = 0; cnt_b = 0;
    end else if (m_bubble && m_ferr) begin
      if (cnt_a < (1 << CW_A) - 1) cnt_a++;
      if (cnt_b < (1 << CW_B) - 1) cnt_b++;
    end
    if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (acc) begin
      m_w[m_pos] = d; m_p[m_pos] = p;
      if (m_pos == FL) begin
        lrc = '0; bad = 1'b0;
        for (int k = 0; k < FL; k++) lrc ^= m_w[k];
        for (int k = 0; k <= FL; k++) bad |= perr(m_w[k], m_p[k]);
        m_ferr = bad | (lrc != m_w[FL]);
        m_bubble = 1'b1;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    #1;
    chk("pec_valid_a", a_pv, acc);
    chk("pec_valid_b", b_pv, acc);
    if (acc) begin
      chk("pec_a", a_pec, perr(d, p));
      chk("pec_b", b_pec, perr(d, p));
    end
    chk("done_a", a_done, m_bubble);
    chk("done_b", b_done, m_bubble);
    if (m_bubble) begin
      chk("ferr_a", a_ferr, m_ferr);
      chk("ferr_b", b_ferr, m_ferr);
    end
    chk("cnt_a", a_cnt, exp_cnt(cnt_a));
    chk("cnt_b", b_cnt, exp_cnt(cnt_b));
  endtask

  task automatic idle(input logic c);
    logic acc;
    step(1'b0, 8'($urandom), 1'($urandom), c, acc);
  endtask

  // Words listed first-to-last from the MSB end; valid stays high until each beat is taken.
  task automatic send_frame(input logic [39:0] wds, input logic [4:0] ps, input logic gaps);
    logic acc;
    int tries;
    for (int i = 0; i <= FL; i++) begin
      if (gaps && $urandom_range(3) == 0) idle(1'($urandom_range(15) == 0));
      tries = 0;
      do begin
        step(1'b1, wds[(FL - i) * 8 +: 8], ps[FL - i], 1'b0, acc);
        tries++;
      end while (!acc && tries < 4);
      if (!acc) chk("accept_timeout", acc, 1'b1);
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'(i);
      #1;
      chk("rst_ready", a_rdy & b_rdy, 1'b1);
      chk("rst_outs", {a_pv, a_pec, a_done, a_ferr, b_pv, b_pec, b_done, b_ferr}, 8'h00);
      chk("rst_cnt", {a_cnt, b_cnt}, 0);
    end
    model_reset();
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  localparam logic [39:0] W_CLEAN = 40'h12_34_56_78_08;
  localparam logic [4:0]  P_CLEAN = 5'b01001;
  localparam logic [39:0] W_WERR  = 40'h13_34_56_78_08;
  localparam logic [39:0] W_LRC   = 40'h12_34_56_78_09;
  localparam logic [4:0]  P_LRC   = 5'b01000;

  initial begin
    logic acc;
    logic [39:0] rw;
    logic [4:0]  rp;
    logic [7:0]  x;
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_par = 1'b0; i_clr = 1'b0;
    model_reset();

    hard_reset();
    idle(1'b0);
    idle(1'b0);

    send_frame(W_CLEAN, P_CLEAN, 1'b0);
    chk("clean_done", a_done, 1'b1);
    chk("clean_ferr", a_ferr, 1'b0);
    idle(1'b0);
    chk("clean_cnt", a_cnt, 0);

    send_frame(W_WERR, P_CLEAN, 1'b0);
    chk("werr_ferr", a_ferr, 1'b1);
    idle(1'b0);
    chk("werr_cnt", a_cnt, exp_cnt(1));

    send_frame(W_LRC, P_LRC, 1'b0);
    chk("lrc_ferr", a_ferr, 1'b1);

    // Back-to-back: the next frame's first beat lands on the bubble and is retried.
    send_frame(W_CLEAN, P_CLEAN, 1'b0);
    send_frame(W_LRC, P_LRC, 1'b0);
    send_frame(W_CLEAN, P_CLEAN, 1'b0);
    idle(1'b0);

    hard_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(W_LRC, P_LRC, 1'b0);
      idle(1'b0);
      chk("sat_cnt", a_cnt, exp_cnt((i < 3) ? i + 1 : 3));
    end
    send_frame(W_WERR, P_CLEAN, 1'b0);
    idle(1'b1);
    chk("clr_cnt", a_cnt, 0);
    chk("clr_cnt_b", b_cnt, 0);

    // Asynchronous reset after two accepted beats; the partial frame must vanish.
    step(1'b1, 8'h12, 1'b0, 1'b0, acc);
    step(1'b1, 8'h34, 1'b1, 1'b0, acc);
    @(negedge clk);
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {a_rdy, a_pv, a_done, b_rdy, b_pv, b_done}, 6'b100100);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b0);
    // The odd instance sees inverted parity, so this is also its clean odd-parity frame.
    send_frame(W_CLEAN, P_CLEAN, 1'b0);
    chk("odd_done", b_done, 1'b1);
    chk("odd_ferr", b_ferr, 1'b0);
    idle(1'b0);

    for (int f = 0; f < 40; f++) begin
      x = '0;
      for (int i = 0; i < FL; i++) begin
        rw[(FL - i) * 8 +: 8] = 8'($urandom);
        x ^= rw[(FL - i) * 8 +: 8];
        rp[FL - i] = ^rw[(FL - i) * 8 +: 8] ^ ($urandom_range(7) == 0);
      end
      rw[7:0] = x ^ (($urandom_range(5) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00);
      rp[0] = ^rw[7:0] ^ ($urandom_range(9) == 0);
      send_frame(rw, rp, 1'b1);
      if ($urandom_range(2) == 0) idle(1'($urandom_range(7) == 0));
    end
    idle(1'b0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
